burst_line_adaptor: RTL and testbench

BURST_LINE_ADAPTOR -- requirements
Module: burst_line_adaptor

---
 rtl/burst_line_adaptor.sv | 112 +++++++++++
 tb/tb_burst_line_adaptor.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/burst_line_adaptor.sv
// Splits cache-line reads/writes into BEATS memory bursts and reassembles read beats into a line.
// Optional build macro BURST_ADAPTOR_CRIT_WORD_FIRST_EN: reads fill from the addressed beat, wrapping.
module burst_line_adaptor #(
  parameter int LINE_W  = 256,
  parameter int BURST_W = 64,
  parameter int ADDR_W  = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                read_i,
  input  logic                write_i,
  input  logic [ADDR_W-1:0]   address_i,
  input  logic [LINE_W-1:0]   line_i,
  output logic [LINE_W-1:0]   line_o,
  output logic                resp_o,
  output logic                read_o,
  output logic                write_o,
  output logic [ADDR_W-1:0]   address_o,
  input  logic [BURST_W-1:0]  burst_i,
  output logic [BURST_W-1:0]  burst_o,
  input  logic                resp_i
);

  localparam int BEATS = LINE_W / BURST_W;
  localparam int CNT_W = (BEATS < 2) ? 1 : $clog2(BEATS);

  if ((LINE_W % BURST_W) != 0 || BEATS < 2 || (BEATS & (BEATS - 1)) != 0) begin : g_bad_cfg
    $error("burst_line_adaptor: LINE_W/BURST_W must be a power of two >= 2");
  end

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t                          state_q, state_d;
  logic [CNT_W-1:0]                cnt_q, cnt_d;
  logic [ADDR_W-1:0]               addr_q;
  logic [BEATS-1:0][BURST_W-1:0]   wr_line_q;
  logic [BEATS-1:0][BURST_W-1:0]   line_q;
  logic [CNT_W-1:0]                start;
  logic [CNT_W-1:0]                slot;
  logic                            last_beat;

`ifdef BURST_ADAPTOR_CRIT_WORD_FIRST_EN
  localparam int OFF_W = (BURST_W >= 16) ? $clog2(BURST_W / 8) : 0;
  assign start = addr_q[OFF_W +: CNT_W];
`else
  assign start = '0;
`endif

  // Slot index wraps naturally because it is exactly log2(BEATS) bits wide.
  assign slot      = start + cnt_q;
  assign last_beat = resp_i && (cnt_q == CNT_W'(BEATS - 1));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    read_o    = 1'b0;
    write_o   = 1'b0;
    resp_o    = 1'b0;
    burst_o   = '0;
    case (state_q)
      IDLE: begin
        if (read_i) begin
          state_d = READ;
          cnt_d   = '0;
        end else if (write_i) begin
          state_d = WRITE;
          cnt_d   = '0;
        end
      end
      READ: begin
        read_o = 1'b1;
        if (resp_i) cnt_d = cnt_q + CNT_W'(1);
        if (last_beat) state_d = DONE;
      end
      WRITE: begin
        write_o = 1'b1;
        burst_o = wr_line_q[cnt_q];
        if (resp_i) cnt_d = cnt_q + CNT_W'(1);
        if (last_beat) state_d = DONE;
      end
      DONE: begin
        resp_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      wr_line_q <= '0;
      line_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == IDLE && read_i) begin
        addr_q <= address_i;
      end else if (state_q == IDLE && write_i) begin
        addr_q    <= address_i;
        wr_line_q <= line_i;
      end
      if (state_q == READ && resp_i) line_q[slot] <= burst_i;
    end
  end

  assign address_o = addr_q;
  assign line_o    = line_q;

endmodule

// File: tb/tb_burst_line_adaptor.sv
// Directed bench for burst_line_adaptor: table-driven read/write flows plus gap, reset,
// critical-word and 8-beat corner sequences.
module tb_burst_line_adaptor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         read_i, write_i, resp_i;
  logic [31:0]  address_i;
  logic [255:0] line_i;
  logic [255:0] line_o;
  logic         resp_o, read_o, write_o;
  logic [31:0]  address_o;
  logic [63:0]  burst_i, burst_o;

  logic         rd8, wr8, rspi8;
  logic [31:0]  adr8, adro8;
  logic [511:0] lin8, lino8;
  logic         rspo8, rdo8, wro8;
  logic [63:0]  bi8, bo8;

  burst_line_adaptor u_dut (
    .clk(clk), .rst(rst), .read_i(read_i), .write_i(write_i), .address_i(address_i),
    .line_i(line_i), .line_o(line_o), .resp_o(resp_o), .read_o(read_o), .write_o(write_o),
    .address_o(address_o), .burst_i(burst_i), .burst_o(burst_o), .resp_i(resp_i)
  );

  burst_line_adaptor #(.LINE_W(512), .BURST_W(64), .ADDR_W(32)) u_dut8 (
    .clk(clk), .rst(rst), .read_i(rd8), .write_i(wr8), .address_i(adr8),
    .line_i(lin8), .line_o(lino8), .resp_o(rspo8), .read_o(rdo8), .write_o(wro8),
    .address_o(adro8), .burst_i(bi8), .burst_o(bo8), .resp_i(rspi8)
  );

  typedef struct {
    logic         rd, wr, rsp;
    logic [63:0]  bst;
    logic [31:0]  adr;
    logic [255:0] lin;
    logic         e_rd, e_wr, e_resp;
    logic [63:0]  e_bst;
    logic [31:0]  e_adr;
  } vec_t;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic vec_t mk(input logic rd, input logic wr, input logic rsp,
                              input logic [63:0] bst, input logic [31:0] adr,
                              input logic [255:0] lin, input logic erd, input logic ewr,
                              input logic eresp, input logic [63:0] ebst,
                              input logic [31:0] eadr);
    vec_t v;
    v.rd = rd; v.wr = wr; v.rsp = rsp; v.bst = bst; v.adr = adr; v.lin = lin;
    v.e_rd = erd; v.e_wr = ewr; v.e_resp = eresp; v.e_bst = ebst; v.e_adr = eadr;
    return v;
  endfunction

  localparam logic [63:0] A = 64'hAAAA_0000_0000_000A, B = 64'hBBBB_0000_0000_000B;
  localparam logic [63:0] C = 64'hCCCC_0000_0000_000C, D = 64'hDDDD_0000_0000_000D;
  localparam logic [63:0] W0 = 64'h1111_2222_3333_0000, W1 = 64'h1111_2222_3333_0001;
  localparam logic [63:0] W2 = 64'h1111_2222_3333_0002, W3 = 64'h1111_2222_3333_0003;
  localparam logic [31:0] JNK = 32'hDEAD_BEEF;
  localparam logic [63:0] JB  = 64'hBAD0_BAD0_BAD0_BAD0;

  vec_t tbl[14];

  initial begin
    logic [255:0] wl, jl, exp_line;
    logic [63:0]  gb[4];
    logic [6:0]   pat;
    logic [511:0] exp8;
    int bi, n_rd8, n_resp8, n_wr8;

    wl = {W3, W2, W1, W0};
    jl = {4{64'hFFFF_FFFF_FFFF_FFFF}};
    // Read of 0x1000 with one cycle of memory latency, then a write with a gap.
    tbl[0]  = mk(1, 0, 0, 0,  32'h1000, 0,  1, 0, 0, 0,  32'h1000);
    tbl[1]  = mk(0, 0, 0, JB, JNK,      0,  1, 0, 0, 0,  32'h1000);
    tbl[2]  = mk(0, 0, 1, A,  JNK,      0,  1, 0, 0, 0,  32'h1000);
    tbl[3]  = mk(0, 0, 1, B,  JNK,      0,  1, 0, 0, 0,  32'h1000);
    tbl[4]  = mk(0, 0, 1, C,  JNK,      0,  1, 0, 0, 0,  32'h1000);
    tbl[5]  = mk(0, 0, 1, D,  JNK,      0,  0, 0, 1, 0,  32'h1000);
    tbl[6]  = mk(0, 0, 0, 0,  JNK,      0,  0, 0, 0, 0,  32'h1000);
    tbl[7]  = mk(0, 1, 0, 0,  32'h2000, wl, 0, 1, 0, W0, 32'h2000);
    tbl[8]  = mk(0, 0, 1, JB, JNK,      jl, 0, 1, 0, W1, 32'h2000);
    tbl[9]  = mk(1, 0, 1, JB, JNK,      jl, 0, 1, 0, W2, 32'h2000);
    tbl[10] = mk(0, 0, 0, JB, JNK,      jl, 0, 1, 0, W2, 32'h2000);
    tbl[11] = mk(0, 0, 1, JB, JNK,      jl, 0, 1, 0, W3, 32'h2000);
    tbl[12] = mk(0, 0, 1, JB, JNK,      jl, 0, 0, 1, 0,  32'h2000);
    tbl[13] = mk(0, 0, 1, JB, JNK,      jl, 0, 0, 0, 0,  32'h2000);

    rst = 1'b1; read_i = 0; write_i = 0; resp_i = 0; address_i = JNK; line_i = jl; burst_i = JB;
    rd8 = 0; wr8 = 0; rspi8 = 0; adr8 = JNK; lin8 = '1; bi8 = JB;
    @(negedge clk);
    step();
    step();
    chk("rst.read_o", 512'(read_o), 512'(0));
    chk("rst.write_o", 512'(write_o), 512'(0));
    chk("rst.resp_o", 512'(resp_o), 512'(0));
    chk("rst.address_o", 512'(address_o), 512'(0));
    chk("rst.burst_o", 512'(burst_o), 512'(0));
    chk("rst.line_o", 512'(line_o), 512'(0));
    chk("rst8.line_o", lino8, 512'(0));

    rst = 1'b0;
    for (int i = 0; i < 14; i++) begin
      read_i = tbl[i].rd; write_i = tbl[i].wr; resp_i = tbl[i].rsp;
      burst_i = tbl[i].bst; address_i = tbl[i].adr; line_i = tbl[i].lin;
      step();
      chk($sformatf("tbl%0d.read_o", i), 512'(read_o), 512'(tbl[i].e_rd));
      chk($sformatf("tbl%0d.write_o", i), 512'(write_o), 512'(tbl[i].e_wr));
      chk($sformatf("tbl%0d.resp_o", i), 512'(resp_o), 512'(tbl[i].e_resp));
      chk($sformatf("tbl%0d.burst_o", i), 512'(burst_o), 512'(tbl[i].e_bst));
      chk($sformatf("tbl%0d.address_o", i), 512'(address_o), 512'(tbl[i].e_adr));
      if (i == 5) chk("read.line_o", 512'(line_o), 512'({D, C, B, A}));
    end
    chk("write_keeps.line_o", 512'(line_o), 512'({D, C, B, A}));
    resp_i = 0;

    // Gapped read: pattern 1,0,0,1,1,0,1 with junk on the bus during gaps.
    gb[0] = 64'hE; gb[1] = 64'hF; gb[2] = 64'h10; gb[3] = 64'h11;
    pat = 7'b1011001;
    read_i = 1; address_i = 32'h3000; step(); read_i = 0; address_i = JNK;
    bi = 0;
    for (int k = 0; k < 7; k++) begin
      resp_i = pat[k];
      burst_i = pat[k] ? gb[bi] : JB;
      if (pat[k]) bi++;
      step();
      chk($sformatf("gap%0d.resp_o", k), 512'(resp_o), 512'(k == 6));
      chk($sformatf("gap%0d.read_o", k), 512'(read_o), 512'(k != 6));
    end
    resp_i = 0;
    chk("gap.line_o", 512'(line_o), 512'({gb[3], gb[2], gb[1], gb[0]}));
    step();
    chk("gap.resp_single", 512'(resp_o), 512'(0));

    // No-gap read at 0x10: minimum latency and critical-word placement.
    read_i = 1; address_i = 32'h10; step(); read_i = 0;
    gb[0] = A; gb[1] = B; gb[2] = C; gb[3] = D;
    for (int k = 0; k < 4; k++) begin
      resp_i = 1; burst_i = gb[k];
      step();
      chk($sformatf("cwf%0d.resp_o", k), 512'(resp_o), 512'(k == 3));
    end
    resp_i = 0;
`ifdef BURST_ADAPTOR_CRIT_WORD_FIRST_EN
    exp_line = {B, A, D, C};
`else
    exp_line = {D, C, B, A};
`endif
    chk("cwf.line_o", 512'(line_o), 512'(exp_line));
    step();

    // Reset after two beats aborts silently; idle resp_i is ignored; next read is clean.
    read_i = 1; address_i = 32'h5000; step(); read_i = 0;
    resp_i = 1; burst_i = A; step();
    burst_i = B; step();
    resp_i = 0; rst = 1; step(); rst = 0;
    chk("abort.read_o", 512'(read_o), 512'(0));
    chk("abort.resp_o", 512'(resp_o), 512'(0));
    chk("abort.line_o", 512'(line_o), 512'(0));
    chk("abort.address_o", 512'(address_o), 512'(0));
    for (int k = 0; k < 3; k++) begin
      resp_i = 1; burst_i = JB;
      step();
      chk($sformatf("abort_idle%0d.resp_o", k), 512'(resp_o), 512'(0));
      chk($sformatf("abort_idle%0d.read_o", k), 512'(read_o), 512'(0));
    end
    resp_i = 0;
    read_i = 1; address_i = 32'h6000; step(); read_i = 0;
    chk("reread.address_o", 512'(address_o), 512'(32'h6000));
    for (int k = 0; k < 4; k++) begin
      resp_i = 1; burst_i = gb[3 - k];
      step();
      chk($sformatf("reread%0d.resp_o", k), 512'(resp_o), 512'(k == 3));
    end
    resp_i = 0;
    chk("reread.line_o", 512'(line_o), 512'({A, B, C, D}));
    step();

    // 8-beat instance: simultaneous read and write, read wins.
    rd8 = 1; wr8 = 1; adr8 = 32'h4000; step(); rd8 = 0; wr8 = 0;
    n_rd8 = 0; n_resp8 = 0; n_wr8 = 0; exp8 = '0;
    if (rdo8) n_rd8++;
    if (wro8) n_wr8++;
    for (int c = 0; c < 11; c++) begin
      rspi8 = (c >= 1 && c <= 8);
      bi8 = rspi8 ? (64'hC0DE_0000_0000_0000 | 64'(c - 1)) : JB;
      if (rspi8) exp8[(c - 1) * 64 +: 64] = bi8;
      step();
      if (rdo8) n_rd8++;
      if (rspo8) n_resp8++;
      if (wro8) n_wr8++;
    end
    rspi8 = 0;
    chk("b8.read_o_cycles", 512'(n_rd8), 512'(9));
    chk("b8.resp_pulses", 512'(n_resp8), 512'(1));
    chk("b8.write_o_cycles", 512'(n_wr8), 512'(0));
    chk("b8.line_o", lino8, exp8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
